// File: rtl/sram_like_slave.sv
// sram_like_slave: responder side of the SRAM-like request/response protocol.
// Accepts at most one request per cycle, performs the memory access at the
// acceptance edge and returns in-order responses a fixed LATENCY cycles later.
// Up to OST requests may be outstanding. The memory array `mem` is never reset.

module sram_like_slave #(
    parameter int MEM_AW  = 12,
    parameter int OST     = 4,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    input  logic        bp_mask
);

    localparam int PW = (OST > 1) ? $clog2(OST) : 1;
    localparam int CW = $clog2(OST + 1);
    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [PW-1:0] PTR_LAST = PW'(OST - 1);
    localparam logic [CW-1:0] OST_C    = CW'(OST);
    localparam logic [LW-1:0] CNT_INIT = LW'(LATENCY - 1);

    logic [31:0]       mem [2**MEM_AW];

    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW-1:0]     head_nxt;
    logic [PW-1:0]     tail_nxt;
    logic [CW-1:0]     count;

    logic [OST-1:0]    q_vld;
    logic              q_wr   [OST];
    logic [31:0]       q_data [OST];
    logic [LW-1:0]     q_cnt  [OST];

    logic [MEM_AW-1:0] idx;
    logic              accept;
    logic              head_ready;
    logic              unused_ok;

    // Handshake, response selection and pointer arithmetic.
    always_comb begin
        idx        = addr[MEM_AW+1:2];
        addr_ok    = !bp_mask && (count < OST_C);
        accept     = req && addr_ok;
        head_ready = q_vld[head] && (q_cnt[head] == '0);
        data_ok    = head_ready;
        rdata      = (head_ready && !q_wr[head]) ? q_data[head] : '0;
        head_nxt   = (head == PTR_LAST) ? '0 : head + 1'b1;
        tail_nxt   = (tail == PTR_LAST) ? '0 : tail + 1'b1;
    end

    // Size and the non-index address bits carry no meaning for this memory.
    always_comb begin
        unused_ok = ^{size, addr[31:MEM_AW+2], addr[1:0]};
    end

    // Byte-masked write into the memory at the acceptance edge.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Response queue: enqueue on acceptance, age entries, pop the ready head.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            q_vld <= '0;
        end else begin
            for (int unsigned i = 0; i < OST; i++) begin
                if (q_vld[i] && (q_cnt[i] != '0)) begin
                    q_cnt[i] <= q_cnt[i] - 1'b1;
                end
            end
            if (head_ready) begin
                q_vld[head] <= 1'b0;
                head        <= head_nxt;
            end
            // The tail slot is always empty when accepting, so this never
            // collides with the head pop or the ageing above.
            if (accept) begin
                q_vld[tail]  <= 1'b1;
                q_wr[tail]   <= wr;
                q_data[tail] <= mem[idx];
                q_cnt[tail]  <= CNT_INIT;
                tail         <= tail_nxt;
            end
            if (accept && !head_ready) begin
                count <= count + 1'b1;
            end else if (!accept && head_ready) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
